// File: rtl/dfp_line_adapter_pkg.sv
// Shared types for the mutative cache memory-side adapter.
// Line geometry and the adapter state encoding live here so the bench and RTL agree.
package mutative_types;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_REQ,
    RD_BEAT,
    RESP
  } adapter_state_t;

endpackage

// File: rtl/dfp_line_adapter.sv
// Splits one 256-bit cache line transaction into four 64-bit burst beats and
// reassembles read beats into a full line before answering the cache.
module dfp_line_adapter
  import mutative_types::*;
#(
  parameter int LINE_WIDTH = mutative_types::LINE_WIDTH,
  parameter int BEAT_WIDTH = mutative_types::BEAT_WIDTH,
  parameter int BEATS      = mutative_types::BEATS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adapter_state_t          state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [LINE_WIDTH-1:0]   line_reg, line_next;
  logic [31:0]             addr_reg, addr_next;
  // Completed read line kept apart from the working buffer so it stays stable
  // through later writes and partially-filled reads.
  logic [LINE_WIDTH-1:0]   rdata_reg, rdata_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      line_reg  <= '0;
      addr_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      line_reg  <= line_next;
      addr_reg  <= addr_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    line_next  = line_reg;
    addr_next  = addr_reg;
    rdata_next = rdata_reg;
    dfp_resp   = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (dfp_write) begin
          addr_next  = {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          line_next  = dfp_wdata;
          state_next = WR_BEAT;
        end else if (dfp_read) begin
          addr_next  = {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          state_next = RD_REQ;
        end
      end

      WR_BEAT: begin
        bmem_write = 1'b1;
        bmem_wdata = line_reg[cnt_reg*BEAT_WIDTH +: BEAT_WIDTH];
        if (bmem_ready) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BEAT) begin
            state_next = RESP;
          end
        end
      end

      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) begin
          state_next = RD_BEAT;
        end
      end

      RD_BEAT: begin
        if (bmem_rvalid) begin
          line_next[cnt_reg*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BEAT) begin
            rdata_next = line_next;
            state_next = RESP;
          end
        end
      end

      RESP: begin
        dfp_resp   = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bmem_addr = addr_reg;
  assign dfp_rdata = rdata_reg;

endmodule

// File: tb/tb_dfp_line_adapter.sv
// Directed-plus-random bench for dfp_line_adapter: the bench plays both the cache
// and a burst memory, predicting beats, data and completion timing from the line protocol.
module tb_dfp_line_adapter;
  import mutative_types::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic                  dfp_resp;
  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  int compared   = 0;
  int mismatched = 0;
  logic [255:0] last_read;

  dfp_line_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // stall_mode: 0 ready always, 1 two-cycle stalls on beats 1 and 3, 2 random stalls
  task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                          input int stall_mode, input bit also_read);
    int k, stalls, held;
    bit done, rdy;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    k = 0; stalls = 0; held = 0; done = 0;
    @(negedge clk);
    dfp_write = 1'b1; dfp_read = also_read; dfp_addr = addr; dfp_wdata = data;
    bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      dfp_wdata = ~data;
      dfp_addr  = ~addr;
      check("wr_no_read", bmem_read, 1'b0);
      if (dfp_resp) begin
        check("wr_resp_cycle", cyc, 5 + stalls);
        check("wr_beat_count", k, 4);
        done = 1'b1;
        dfp_write = 1'b0; dfp_read = 1'b0;
      end else begin
        check("wr_write_active", bmem_write, 1'b1);
        if (bmem_write) begin
          check("wr_addr", bmem_addr, exp_addr);
          if (k < 4) check("wr_beat_data", bmem_wdata, data[64*k +: 64]);
          else check("wr_extra_beat", k, 3);
          if (stall_mode == 1) rdy = !((k == 1 || k == 3) && held < 2);
          else if (stall_mode == 2) rdy = ($urandom_range(0, 2) != 0);
          else rdy = 1'b1;
          bmem_ready = rdy;
          if (rdy) begin k++; held = 0; end
          else begin stalls++; held++; end
        end
      end
    end
    if (!done) check("wr_timeout", 1'b0, 1'b1);
    @(negedge clk);
    check("wr_resp_one_cycle", dfp_resp, 1'b0);
    check("wr_rdata_held", dfp_rdata, last_read);
    bmem_ready = 1'b0;
    $display("write addr=%08h mode=%0d stalls=%0d", addr, stall_mode, stalls);
  endtask

  // gap_mode: 0 back-to-back beats, 1 one-cycle gaps plus a spurious beat before accept, 2 random
  task automatic do_read(input logic [31:0] addr, input logic [255:0] data,
                         input int gap_mode, input int abort_at);
    int k, last, phase;
    bit done, toggle;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    k = 0; last = -1; phase = 0; done = 0; toggle = 1'b1;
    @(negedge clk);
    dfp_read = 1'b1; dfp_write = 1'b0; dfp_addr = addr;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      dfp_addr    = ~addr;
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
      if (abort_at > 0 && phase == 1 && k == abort_at) begin
        rst_n = 1'b0; dfp_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          check("abort_no_resp", dfp_resp, 1'b0);
          check("abort_rdata", dfp_rdata, 256'd0);
          check("abort_no_req", bmem_read, 1'b0);
          @(negedge clk);
        end
        $display("read addr=%08h aborted after %0d beats", addr, k);
        return;
      end
      if (dfp_resp) begin
        check("rd_resp_cycle", cyc, last + 1);
        check("rd_beat_count", k, 4);
        check("rd_data", dfp_rdata, data);
        done = 1'b1;
        dfp_read = 1'b0; bmem_ready = 1'b0;
      end else if (phase == 0) begin
        check("rd_req", bmem_read, 1'b1);
        check("rd_addr", bmem_addr, exp_addr);
        if ((gap_mode == 1 && cyc == 1) || $urandom_range(0, 2) == 0) begin
          bmem_ready = 1'b0;
          bmem_rvalid = 1'b1;
        end else begin
          bmem_ready = 1'b1;
          phase = 1;
        end
      end else begin
        check("rd_req_dropped", bmem_read, 1'b0);
        bmem_ready = 1'b0;
        if (k < 4 && (gap_mode == 0 || (gap_mode == 1 && toggle) ||
                      (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = data[64*k +: 64];
          last = cyc;
          k++;
        end
        toggle = !toggle;
      end
    end
    if (!done) check("rd_timeout", 1'b0, 1'b1);
    @(negedge clk);
    check("rd_resp_one_cycle", dfp_resp, 1'b0);
    last_read = data;
    $display("read  addr=%08h gap=%0d beats=%0d", addr, gap_mode, k);
  endtask

  initial begin
    logic [255:0] line;
    rst_n = 1'b0; dfp_read = 1'b1; dfp_write = 1'b0; dfp_addr = 32'h8000_0040;
    dfp_wdata = '0; bmem_ready = 1'b1; bmem_rdata = '0; bmem_rvalid = 1'b0;
    last_read = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_resp", dfp_resp, 1'b0);
      check("rst_rdata", dfp_rdata, 256'd0);
      check("rst_read", bmem_read, 1'b0);
      check("rst_write", bmem_write, 1'b0);
      check("rst_addr", bmem_addr, 32'd0);
      check("rst_wdata", bmem_wdata, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_read", bmem_read, 1'b1);
    check("rel_addr", bmem_addr, 32'h8000_0040);
    rst_n = 1'b0; dfp_read = 1'b0;
    @(negedge clk);
    check("rel_abort_read", bmem_read, 1'b0);
    check("rel_abort_resp", dfp_resp, 1'b0);
    rst_n = 1'b1;
    $display("reset sequence done");

    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_write(32'h1234_5678, line, 0, 1'b0);
    do_write(32'h1234_5678, line, 1, 1'b0);

    line = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
            64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    do_read(32'h8000_0040, line, 1, 0);

    do_write(32'h0000_1020, rand_line(), 0, 1'b1);

    do_read(32'h4000_0080, rand_line(), 0, 2);
    last_read = '0;
    do_read(32'h4000_0080, rand_line(), 2, 0);

    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) do_write($urandom, rand_line(), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      else do_read($urandom, rand_line(), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
